mem_port_arbiter: RTL
=====================

# mem_port_arbiter

Shares the core's single unified memory port between the fetch stage (instruction reads) and the LSU (data loads/stores), one transaction in flight at a time. It sits between `fetch_stage`/`lsu` and the memory, and its grant/valid signals are what the fetch and execute stages turn into `if_stall`/`ex_stall`. The LSU wins contention by default. A wait counter bounds fetch starvation, and a branch flush discards a stale in-flight fetch response.

## Interface
Parameters:
- `ADDR_W`, 32: byte-address width.
- `DATA_W`, 32: data width; byte-enable width is `DATA_W/8`.
- `MAX_WAIT`, 4: consecutive LSU wins over a pending fetch before the fetch is forced to priority (≥1).

Ports:
- `clk`  in  1  clock; all state on rising edge.
- `rst`  in  1  asynchronous, active-low reset.
- `if_req`  in  1  fetch read request; held until `if_gnt`.
- `if_addr`  in  ADDR_W  fetch address.
- `if_flush`  in  1  branch taken (`ex_if_take_branch`); kills in-flight fetch response.
- `if_gnt`  out  1  fetch request accepted this cycle.
- `if_rvalid`  out  1  fetch data valid.
- `if_rdata`  out  DATA_W  fetch data (= `mem_rdata`).
- `lsu_req`, `lsu_we`  in  1  data request / write enable; held until `lsu_gnt`.
- `lsu_addr`  in  ADDR_W; `lsu_wdata`  in  DATA_W; `lsu_be`  in  DATA_W/8.
- `lsu_gnt`, `lsu_rvalid`  out  1  accept / response (write ack or load data).
- `lsu_rdata`  out  DATA_W  (= `mem_rdata`).
- `mem_req`, `mem_we`  out  1; `mem_addr` out ADDR_W; `mem_wdata` out DATA_W; `mem_be` out DATA_W/8.
- `mem_ready`  in  1  memory accepts request this cycle.
- `mem_rvalid`  in  1  response for the outstanding request (reads and writes).
- `mem_rdata`  in  DATA_W.
- `busy`  out  1  transaction outstanding.

## Operation
- FSM states: IDLE (no outstanding transaction), RESP (one outstanding, owner recorded in `owner` = IF/LSU).
- Issue allowed when state==IDLE, or state==RESP && `mem_rvalid` (back-to-back).
- Selection when issue allowed: if only one requester, it wins; if both, LSU wins unless `wait_cnt == MAX_WAIT`, then IF wins.
- `mem_req` = issue allowed && (`if_req` || `lsu_req`). Address, data, byte-enables and `we` are muxed from the selected requester. For IF: `mem_we`=0 and `mem_be`=all ones.
- Grant: `x_gnt` = `mem_req` && `mem_ready` && x selected. On grant: next state RESP, `owner` <= selected. Without grant the request stays pending; selection is re-evaluated next cycle.
- Response: in RESP, `mem_rvalid` asserts `lsu_rvalid` if owner==LSU. It asserts `if_rvalid` if owner==IF && !`drop` && !`if_flush`. If no new grant in the same cycle, next state is IDLE.
- `drop` flag: set when `if_flush` is seen while owner==IF in RESP without `mem_rvalid`. Cleared when that response arrives. A flush with no IF transaction outstanding has no effect. A flush never cancels a pending ungranted `if_req`.
- `wait_cnt`: increments (saturating at MAX_WAIT) each cycle `lsu_gnt` fires while `if_req`=1. Clears on `if_gnt`. Unchanged otherwise.
- `busy` = (state==RESP).
- `mem_rvalid` in IDLE is a protocol error: ignored, no rvalid out.

## Timing
- Reset (rst=0, async): state IDLE, `owner`=IF, `drop`=0, `wait_cnt`=0. `mem_req`, `if_gnt`, `lsu_gnt`, `if_rvalid`, `lsu_rvalid`, `busy` are all 0.
- Grant is combinational from `mem_ready` in the issue cycle. Response appears in the same cycle as `mem_rvalid` (zero added latency).
- With a 1-cycle memory, peak throughput is one transaction per cycle.
- Reset asserted mid-transaction: the outstanding response is abandoned and the FSM returns to IDLE. A `mem_rvalid` arriving after reset release is ignored.

## Test plan
- Fetch only, `mem_ready`=1, 1-cycle memory, addr 0x0,0x4,0x8: `if_gnt` fires 3 consecutive cycles. Each `if_rvalid` follows one cycle later with the matching data. `lsu_*` stays 0.
- Both requesting in IDLE, LSU store 0xDEADBEEF to 0x100 with be=4'b1111: LSU granted first, `mem_we`=1. IF granted in the `mem_rvalid` cycle. `wait_cnt` goes 1 then 0.
- LSU requests continuously with `if_req` held, MAX_WAIT=4: exactly 4 LSU grants, then `if_gnt` on the 5th issue slot, then the LSU resumes.
- Fetch of 0x20 granted, memory delays response 3 cycles, `if_flush` pulses in cycle 1: `mem_rvalid` arrives, `if_rvalid` stays 0, `drop` clears. The next fetch's response is delivered normally.
- `if_flush` coincident with `mem_rvalid` for an IF transaction: `if_rvalid`=0. A flush while an LSU transaction is outstanding: `lsu_rvalid` is delivered unaffected.
- `rst` dropped low while in RESP: `busy`=0 and all grants/valids are 0 immediately. A stray `mem_rvalid` after release yields no rvalid.

Source files
------------

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares one memory port between fetch and LSU.
// One transaction in flight; LSU favoured, fetch starvation bounded.
module mem_port_arbiter #(
  parameter int ADDR_W   = 32,
  parameter int DATA_W   = 32,
  parameter int MAX_WAIT = 4
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                if_req,
  input  logic [ADDR_W-1:0]   if_addr,
  input  logic                if_flush,
  output logic                if_gnt,
  output logic                if_rvalid,
  output logic [DATA_W-1:0]   if_rdata,
  input  logic                lsu_req,
  input  logic                lsu_we,
  input  logic [ADDR_W-1:0]   lsu_addr,
  input  logic [DATA_W-1:0]   lsu_wdata,
  input  logic [DATA_W/8-1:0] lsu_be,
  output logic                lsu_gnt,
  output logic                lsu_rvalid,
  output logic [DATA_W-1:0]   lsu_rdata,
  output logic                mem_req,
  output logic                mem_we,
  output logic [ADDR_W-1:0]   mem_addr,
  output logic [DATA_W-1:0]   mem_wdata,
  output logic [DATA_W/8-1:0] mem_be,
  input  logic                mem_ready,
  input  logic                mem_rvalid,
  input  logic [DATA_W-1:0]   mem_rdata,
  output logic                busy
);

  localparam int BE_W = DATA_W / 8;
  localparam int CW   = $clog2(MAX_WAIT + 1);
  localparam logic [CW-1:0] WMAX = CW'(MAX_WAIT);

  typedef enum logic {IDLE, RESP} state_t;
  typedef enum logic {OWN_IF, OWN_LSU} owner_t;

  state_t        state;
  state_t        state_nx;
  owner_t        owner;
  logic          drop;
  logic [CW-1:0] wait_cnt;

  logic resp;
  logic issue_ok;
  logic sel_lsu;
  logic any_gnt;

  assign if_rdata  = mem_rdata;
  assign lsu_rdata = mem_rdata;

  // Issue selection, port mux, grants, responses and next state.
  always_comb begin
    resp       = 1'b0;
    issue_ok   = 1'b0;
    sel_lsu    = 1'b0;
    mem_req    = 1'b0;
    mem_we     = 1'b0;
    mem_addr   = if_addr;
    mem_wdata  = '0;
    mem_be     = {BE_W{1'b1}};
    if_gnt     = 1'b0;
    lsu_gnt    = 1'b0;
    if_rvalid  = 1'b0;
    lsu_rvalid = 1'b0;
    any_gnt    = 1'b0;
    state_nx   = state;
    busy       = (state == RESP);

    resp     = rst && (state == RESP) && mem_rvalid;
    issue_ok = rst && ((state == IDLE) || resp);
    sel_lsu  = lsu_req && (!if_req || (wait_cnt != WMAX));
    mem_req  = issue_ok && (if_req || lsu_req);

    if (sel_lsu) begin
      mem_we    = lsu_we;
      mem_addr  = lsu_addr;
      mem_wdata = lsu_wdata;
      mem_be    = lsu_be;
    end

    if_gnt  = mem_req && mem_ready && !sel_lsu;
    lsu_gnt = mem_req && mem_ready && sel_lsu;
    any_gnt = if_gnt || lsu_gnt;

    lsu_rvalid = resp && (owner == OWN_LSU);
    if_rvalid  = resp && (owner == OWN_IF) && !drop && !if_flush;

    if (any_gnt)   state_nx = RESP;
    else if (resp) state_nx = IDLE;
  end

  // FSM state and owner of the outstanding transaction.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= IDLE;
      owner <= OWN_IF;
    end else begin
      state <= state_nx;
      if (any_gnt) owner <= sel_lsu ? OWN_LSU : OWN_IF;
    end
  end

  // Remember that the outstanding fetch was overtaken by a branch.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      drop <= 1'b0;
    end else if (resp) begin
      drop <= 1'b0;
    end else if (state == RESP && owner == OWN_IF && if_flush) begin
      drop <= 1'b1;
    end
  end

  // Count LSU wins over a waiting fetch, saturating at the limit.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wait_cnt <= '0;
    end else if (if_gnt) begin
      wait_cnt <= '0;
    end else if (lsu_gnt && if_req && wait_cnt != WMAX) begin
      wait_cnt <= wait_cnt + CW'(1);
    end
  end

endmodule
